bcd_display_scanner: RTL

BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

---
 rtl/bcd_display_scanner_pkg.sv | 29 ++
 rtl/bcd_display_scanner_conv.sv | 64 ++++++
 rtl/bcd_display_scanner.sv | 83 ++++++++
 3 files changed

// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants, converter state encoding and helpers for the BCD display scanner.
package bcd_display_scanner_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int VALUE_W    = 14;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  localparam logic [VALUE_W-1:0] MAX_DISPLAY = 14'd9999;

  localparam logic [3:0] AN_ALL_OFF = 4'b1111;
  localparam logic [3:0] AN_DIGIT [NUM_DIGITS] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_e;

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3Correct(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_display_scanner_conv.sv
// Sequential binary-to-BCD converter, one shift-add-3 iteration per clock.
module bin_to_bcd_seq
  import bcd_display_scanner_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [VALUE_W-1:0] bin,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);

  conv_state_e        state_q, state_d;
  logic [3:0]         bitCnt_q, bitCnt_d;
  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   bcdAdj;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    bcdAdj   = add3Correct(bcd_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT;
          bitCnt_d = 4'd13;
          bin_d    = bin;
          bcd_d    = '0;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcdAdj, bin_q} << 1;
        if (bitCnt_q == 4'd0) state_d = DONE;
        else bitCnt_d = bitCnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Busy rises one cycle after capture; the top blocks a second capture in that cycle itself.
  assign busy = ((state_q == SHIFT) && (bitCnt_q != 4'd13)) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/bcd_display_scanner.sv
// Four-digit multiplexed display driver: captures a binary value, converts it to BCD and scans it.
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  output logic [3:0]         LED_BCD,
  output logic [3:0]         AN,
  output logic               busy,
  output logic               overflow
);

  localparam int              PRE_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  logic               convBusy;
  logic               convDone;
  logic [BCD_W-1:0]   convBcd;
  logic               accept;
  logic [VALUE_W-1:0] satValue;

  logic               started_q;
  logic               overflow_q;
  logic [BCD_W-1:0]   digits_q;
  logic [PRE_W-1:0]   pre_q;
  logic [1:0]         idx_q;

  logic [1:0]         msd;
  logic               blank;

  assign accept   = load && !convBusy && !started_q;
  assign satValue = (value > MAX_DISPLAY) ? MAX_DISPLAY : value;

  bin_to_bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .bin   (satValue),
    .busy  (convBusy),
    .done  (convDone),
    .bcd   (convBcd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      started_q  <= 1'b0;
      overflow_q <= 1'b0;
      digits_q   <= '0;
      pre_q      <= '0;
      idx_q      <= '0;
    end else begin
      started_q <= accept;
      if (accept) overflow_q <= (value > MAX_DISPLAY);
      if (convDone) digits_q <= convBcd;
      if (pre_q == PRE_LAST) begin
        pre_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

  // Blanked slots keep their full period; only the anode is suppressed, never digit 0.
  always_comb begin
    msd = 2'd0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (digits_q[4*i +: 4] != 4'd0) msd = 2'(i);
    end
    blank   = BLANK_LZ && (idx_q > msd);
    LED_BCD = digits_q[{idx_q, 2'b00} +: 4];
    AN      = blank ? AN_ALL_OFF : AN_DIGIT[idx_q];
  end

  assign busy     = convBusy;
  assign overflow = overflow_q;

endmodule
